// File: rtl/goldschmidt_divider.sv
// goldschmidt_divider: self-sequencing Goldschmidt divider, U1.(WIDTH-1) operands.
// One shared WIDTH x WIDTH multiplier alternates between the N and D updates
// for ITER iterations; quotient q is presented with a one-cycle done pulse.
// Build option: define GOLDSCHMIDT_ROUND_EN to round every multiply result to
// nearest (ties up) instead of truncating. Latency is the same in both builds.
module goldschmidt_divider #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] IA,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULN = 2'd1;
  localparam logic [1:0] MULD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state, state_d;
  logic [WIDTH-1:0] nreg, nreg_d;
  logic [WIDTH-1:0] dreg, dreg_d;
  logic [WIDTH-1:0] kreg, kreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] q_d;
  logic             busy_d, done_d;

  logic [WIDTH-1:0] mul_a;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_adj;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] k_next;
  logic             unused_prod_bits;

  // Shared multiplier: nreg in MULN, dreg in MULD, always against kreg
  always_comb begin
    mul_a = (state == MULD) ? dreg : nreg;
    prod  = PW'(mul_a) * PW'(kreg);
`ifdef GOLDSCHMIDT_ROUND_EN
    prod_adj = prod + (PW'(1) << (WIDTH - 2));
`else
    prod_adj = prod;
`endif
    mul_res          = prod_adj[PW-2:WIDTH-1];
    k_next           = (~mul_res) + WIDTH'(1);
    unused_prod_bits = ^{prod_adj[PW-1], prod_adj[WIDTH-2:0]};
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d = state;
    nreg_d  = nreg;
    dreg_d  = dreg;
    kreg_d  = kreg;
    cnt_d   = cnt;
    q_d     = q;
    case (state)
      IDLE: begin
        if (start) begin
          nreg_d  = N;
          dreg_d  = D;
          kreg_d  = IA;
          cnt_d   = CW'(0);
          state_d = MULN;
        end
      end
      MULN: begin
        nreg_d  = mul_res;
        state_d = MULD;
      end
      MULD: begin
        dreg_d = mul_res;
        kreg_d = k_next;
        if (cnt == CW'(ITER - 1)) begin
          q_d     = nreg;
          state_d = DONE;
        end else begin
          cnt_d   = cnt + CW'(1);
          state_d = MULN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      nreg  <= '0;
      dreg  <= '0;
      kreg  <= '0;
      cnt   <= '0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      nreg  <= nreg_d;
      dreg  <= dreg_d;
      kreg  <= kreg_d;
      cnt   <= cnt_d;
      q     <= q_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

endmodule

// File: tb/tb_goldschmidt_divider.sv
// tb_goldschmidt_divider: directed vectors for three divider configurations
// (ITER=3, ITER=4, ITER=1; WIDTH=16) plus reset, busy-ignore and streaming sequences.
module tb_goldschmidt_divider;

  logic        clk;
  logic        reset;
  logic [15:0] N, D, IA;
  logic        start_i [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic [15:0] q_o     [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] n;
    logic [15:0] d;
    logic [15:0] ia;
    logic [15:0] q;
  } vec_t;

  vec_t vecs [5];

  goldschmidt_divider #(.WIDTH(16), .ITER(3)) dut3 (
    .clk(clk), .reset(reset), .start(start_i[0]), .N(N), .D(D), .IA(IA),
    .busy(busy_o[0]), .done(done_o[0]), .q(q_o[0])
  );

  goldschmidt_divider #(.WIDTH(16), .ITER(4)) dut4 (
    .clk(clk), .reset(reset), .start(start_i[1]), .N(N), .D(D), .IA(IA),
    .busy(busy_o[1]), .done(done_o[1]), .q(q_o[1])
  );

  goldschmidt_divider #(.WIDTH(16), .ITER(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_i[2]), .N(N), .D(D), .IA(IA),
    .busy(busy_o[2]), .done(done_o[2]), .q(q_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One operation on instance idx: checks busy, done latency, q, and return to idle
  task automatic run(input int idx, input logic [15:0] n, input logic [15:0] d,
                     input logic [15:0] ia, input logic [15:0] eq, input int lat,
                     input string tag);
    int cyc;
    logic seen;
    N = n; D = d; IA = ia;
    start_i[idx] = 1'b1;
    @(posedge clk); #1;
    start_i[idx] = 1'b0;
    chk({tag, " busy"}, 32'(busy_o[idx]), 32'd1);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (done_o[idx]) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    chk({tag, " q"}, 32'(q_o[idx]), 32'(eq));
    @(posedge clk); #1;
    chk({tag, " done pulse"}, 32'(done_o[idx]), 32'd0);
    chk({tag, " busy after"}, 32'(busy_o[idx]), 32'd0);
    chk({tag, " q held"}, 32'(q_o[idx]), 32'(eq));
  endtask

  initial begin
    int ndone;
    logic exp_done, exp_busy;

    // Expected quotients computed by hand in U1.15
    vecs[0] = '{n: 16'h4000, d: 16'h0000, ia: 16'h8000, q: 16'h0000};
`ifdef GOLDSCHMIDT_ROUND_EN
    vecs[1] = '{n: 16'h8000, d: 16'h4000, ia: 16'hFFFF, q: 16'hFFFF};
    vecs[2] = '{n: 16'h2000, d: 16'h4000, ia: 16'hFFFF, q: 16'h4000};
`else
    vecs[1] = '{n: 16'h8000, d: 16'h4000, ia: 16'hFFFF, q: 16'h0000};
    vecs[2] = '{n: 16'h2000, d: 16'h4000, ia: 16'hFFFF, q: 16'h3FFF};
`endif
    vecs[3] = '{n: 16'h4000, d: 16'h6000, ia: 16'h8000, q: 16'h5500};
    vecs[4] = '{n: 16'h6000, d: 16'h6000, ia: 16'hAAAB, q: 16'h8000};

    reset = 1'b1;
    N = '0; D = '0; IA = '0;
    for (int i = 0; i < 3; i++) start_i[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset q[%0d]", i), 32'(q_o[i]), 32'd0);
      chk($sformatf("reset done[%0d]", i), 32'(done_o[i]), 32'd0);
      chk($sformatf("reset busy[%0d]", i), 32'(busy_o[i]), 32'd0);
    end

    for (int v = 0; v < 5; v++)
      run(0, vecs[v].n, vecs[v].d, vecs[v].ia, vecs[v].q, 6, $sformatf("iter3 vec%0d", v));

    run(1, 16'h4000, 16'h6000, 16'h8000, 16'h5555, 8, "iter4");
`ifdef GOLDSCHMIDT_ROUND_EN
    run(2, 16'h0001, 16'h6000, 16'hC000, 16'h0002, 2, "iter1 lsb");
`else
    run(2, 16'h0001, 16'h6000, 16'hC000, 16'h0001, 2, "iter1 lsb");
`endif

    // Reset mid-operation after an ignored start during MULD
    N = 16'h4000; D = 16'h6000; IA = 16'h8000;
    start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    @(posedge clk); #1;
    N = 16'h7FFF;
    start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    chk("busy start ignored", 32'(busy_o[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset q", 32'(q_o[0]), 32'd0);
    chk("midreset done", 32'(done_o[0]), 32'd0);
    chk("midreset busy", 32'(busy_o[0]), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_o[0]) ndone++;
    end
    chk("midreset no done", 32'(ndone), 32'd0);
    run(0, 16'h4000, 16'h6000, 16'h8000, 16'h5500, 6, "after reset");

    // Start held high: one result every 8 cycles
    N = 16'h4000; D = 16'h6000; IA = 16'h8000;
    start_i[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (k == 19) start_i[0] = 1'b0;
      exp_done = (k == 6) || (k == 14) || (k == 22);
      exp_busy = !((k == 7) || (k == 15) || (k >= 23));
      chk($sformatf("stream done k%0d", k), 32'(done_o[0]), 32'(exp_done));
      chk($sformatf("stream busy k%0d", k), 32'(busy_o[0]), 32'(exp_busy));
      if (k >= 6) chk($sformatf("stream q k%0d", k), 32'(q_o[0]), 32'h5500);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
